// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          CNT_W     = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/fetch_stage_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (en && (count != {W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, IF/ID pipeline register, and stall/squash statistics.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             branch_taken_i,
    input  logic [31:0]      branch_target_i,
    input  logic             jump_i,
    input  logic [31:0]      jump_target_i,
    input  logic [31:0]      imem_instr_i,
    output logic [31:0]      imem_addr_o,
    output logic [31:0]      ifid_pc_o,
    output logic [31:0]      ifid_instr_o,
    output logic             ifid_valid_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] target;
    logic        run;
    logic        redirect;
    logic        stall_en;
    logic        flush_en;

    assign run      = (state == RUN);
    assign redirect = branch_taken_i || jump_i;
    // Branch beats jump when both fire in the same cycle.
    assign target   = branch_taken_i ? branch_target_i : jump_target_i;
    assign pc_next  = pc + PC_STEP;

    assign stall_en = run && !redirect && !flush_i && stall_i;
    assign flush_en = run && (redirect || flush_i);

    assign imem_addr_o = pc;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            ifid_pc_o    <= 32'h0;
            ifid_instr_o <= NOP_INSTR;
            ifid_valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i)
                        state <= RUN;
                end
                RUN: begin
                    if (redirect) begin
                        pc           <= {target[31:2], 2'b00};
                        ifid_pc_o    <= 32'h0;
                        ifid_instr_o <= NOP_INSTR;
                        ifid_valid_o <= 1'b0;
                    end else if (flush_i) begin
                        pc           <= pc_next;
                        ifid_pc_o    <= 32'h0;
                        ifid_instr_o <= NOP_INSTR;
                        ifid_valid_o <= 1'b0;
                    end else if (!stall_i) begin
                        pc           <= pc_next;
                        ifid_pc_o    <= pc_next;
                        ifid_instr_o <= imem_instr_i;
                        ifid_valid_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk_i),
        .rst_n (rst_i),
        .en    (stall_en),
        .count (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk_i),
        .rst_n (rst_i),
        .en    (flush_en),
        .count (flush_cnt_o)
    );

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk_i, rst_i.
REQ-002 clk_i  input  1  clock; all state updates on rising edge.
REQ-003 rst_i  input  1  asynchronous active-low reset.
REQ-004 start_i  input  1  leaves IDLE when sampled high.
REQ-005 stall_i  input  1  hold request from hazard detection; 1 = hold PC and IF/ID.
REQ-006 flush_i  input  1  squash IF/ID contents; PC unaffected.
REQ-007 branch_taken_i  input  1  redirect PC to branch_target_i.
REQ-008 branch_target_i  input  32  branch destination.
REQ-009 jump_i  input  1  redirect PC to jump_target_i.
REQ-010 jump_target_i  input  32  jump destination.
REQ-011 imem_instr_i  input  32  instruction word at imem_addr_o, same cycle.
REQ-012 imem_addr_o  output  32  current PC, driven combinationally from the PC register.
REQ-013 ifid_pc_o  output  32  registered PC+4 of the latched instruction.
REQ-014 ifid_instr_o  output  32  registered instruction.
REQ-015 ifid_valid_o  output  1  1 = ifid_instr_o is a real instruction, 0 = bubble.
REQ-016 stall_cnt_o  output  16  saturating count of stall cycles honoured.
REQ-017 flush_cnt_o  output  16  saturating count of squash cycles.

Function
REQ-018 States SHALL be IDLE and RUN; IDLE->RUN when start_i=1; RUN is left only by reset.
REQ-019 In IDLE, PC, IF/ID registers and counters SHALL hold; stall_i, flush_i, branch_taken_i and jump_i SHALL be ignored.
REQ-020 In RUN, priority per cycle SHALL be: redirect (branch_taken_i or jump_i) > flush_i > stall_i > normal.
REQ-021 branch_taken_i and jump_i both high: branch_target_i SHALL win.
REQ-022 Redirect: PC <= target with bits [1:0] forced to 0; ifid_instr_o <= 0 (NOP), ifid_valid_o <= 0, ifid_pc_o <= 0.
REQ-023 flush_i without redirect: PC <= PC+4; IF/ID loaded as NOP/invalid as in REQ-022.
REQ-024 stall_i without redirect or flush: PC and all IF/ID registers SHALL hold their values.
REQ-025 Normal: PC <= PC+4; ifid_pc_o <= PC+4; ifid_instr_o <= imem_instr_i; ifid_valid_o <= 1.
REQ-026 PC arithmetic SHALL be 32-bit modulo; 0xFFFFFFFC+4 wraps to 0x00000000.
REQ-027 Latency: an instruction presented at imem_addr_o=A SHALL appear on ifid_instr_o one cycle later, with ifid_pc_o=A+4.
REQ-028 stall_cnt_o SHALL increment by 1 each RUN cycle where REQ-024 applies; flush_cnt_o SHALL increment by 1 each RUN cycle where REQ-022 or REQ-023 applies.
REQ-029 Both counters SHALL saturate at 0xFFFF and never wrap.

Reset
REQ-030 rst_i low SHALL immediately force: state IDLE, PC=0, ifid_pc_o=0, ifid_instr_o=0, ifid_valid_o=0, stall_cnt_o=0, flush_cnt_o=0.
REQ-031 Reset asserted mid-stall or mid-redirect SHALL discard the pending operation; after release, fetch restarts from PC=0 once start_i is seen.

Structure
REQ-032 A shared package SHALL hold NOP_INSTR (32'h0), PC_STEP (4), RESET_PC (32'h0), CNT_W (16), and the IDLE/RUN state encoding.
REQ-033 Counters SHALL use one sub-module, sat_counter (width-parameterised, enable input, saturate at all-ones), instantiated twice.

Verification
REQ-034 Reset, start_i=1, no hazards, imem returns 0x20080005 at 0x0 -> next cycle ifid_instr_o=0x20080005, ifid_pc_o=0x4, valid=1, imem_addr_o=0x4.
REQ-035 RUN at PC=0x10, stall_i=1 for 2 cycles -> imem_addr_o stays 0x10 and IF/ID unchanged for 2 cycles, stall_cnt_o=2, then resumes 0x14.
REQ-036 PC=0x20, branch_taken_i=1, jump_i=1, stall_i=1, branch_target_i=0x103, jump_target_i=0x200 -> PC=0x100, ifid_valid_o=0, ifid_instr_o=0, flush_cnt_o=1, stall_cnt_o unchanged.
REQ-037 PC=0xFFFFFFFC, normal cycle -> PC=0x00000000, ifid_pc_o=0x00000000, valid=1.
REQ-038 Force stall_cnt_o to 0xFFFE, 3 stall cycles -> stall_cnt_o reads 0xFFFF and stays.
REQ-039 Assert rst_i low between clock edges during a stall -> all outputs 0 without waiting for a clock edge; state IDLE until start_i.
